// File: rtl/rot_buffer_scheduler.sv
// rot_buffer_scheduler: sole owner of rot_frame_buffer's control port; arbitrates display reads, voxel writes, flushes.
// Latency: read grant -> col_valid 3 cycles; write/flush strobe 1 cycle after grant, then wait on buf_busy.
// Backpressure: vox_ready drops while the voxel FIFO is full; ops are never preempted, others wait in pending flags.
// Ports: clk_in/rst_in (sync, active-high); vox_* rasteriser write stream; flush_req/flush_done frame sequencer;
//        disp_theta encoder angle; col_valid/col_theta read result strobe; buf_* buffer control; read_miss_count.
// Build option: define ROT_SCHED_STATS_EN to build the saturating read_miss_count; otherwise it is tied to 0.
module rot_buffer_scheduler #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int DISPLAY_RADIUS = 32,
  parameter int DISPLAY_HEIGHT = 64,
  parameter int FIFO_DEPTH     = 16,
  localparam int TW = $clog2(ROTATIONAL_RES),
  localparam int RW = $clog2(DISPLAY_RADIUS),
  localparam int ZW = $clog2(DISPLAY_HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          vox_valid,
  output logic          vox_ready,
  input  logic [RW-1:0] vox_radius,
  input  logic [TW-1:0] vox_theta,
  input  logic [ZW-1:0] vox_z,
  input  logic          flush_req,
  output logic          flush_done,
  input  logic [TW-1:0] disp_theta,
  output logic          col_valid,
  output logic [TW-1:0] col_theta,
  output logic          buf_flush,
  output logic          buf_new_data,
  output logic [RW-1:0] buf_radius,
  output logic [TW-1:0] buf_theta_write,
  output logic [ZW-1:0] buf_z,
  output logic [TW-1:0] buf_theta_read,
  input  logic          buf_busy,
  output logic [15:0]   read_miss_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int VW = RW + TW + ZW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FL_ISSUE, FL_WAIT} state_t;

  state_t        state;
  logic          wait_skip;   // first cycle of a *_WAIT state
  logic [TW-1:0] disp_q;
  logic [TW-1:0] rd_theta;
  logic          rd_pend;
  logic          rd_new;      // a newer angle arrived while a read was in flight
  logic          fl_pend;

  // Voxel FIFO
  logic [VW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;

  logic theta_chg, in_rd, idle_free, grant_rd, grant_fl, grant_wr, rd_done, fl_exit;

  assign theta_chg = (disp_theta != disp_q);
  assign in_rd     = (state == RD_ISSUE) || (state == RD_WAIT);
  assign idle_free = (state == IDLE) && !buf_busy;
  assign grant_rd  = idle_free && rd_pend;
  assign grant_fl  = idle_free && !rd_pend && fl_pend;
  assign grant_wr  = idle_free && !rd_pend && !fl_pend && (count != '0);
  assign rd_done   = (state == RD_WAIT) && !wait_skip;
  assign fl_exit   = (state == FL_WAIT) && !wait_skip && !buf_busy;

  assign push = vox_valid && vox_ready;
  assign pop  = grant_wr;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {vox_radius, vox_theta, vox_z};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      vox_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      // Registered so a pop on a full FIFO frees the slot only from the next cycle.
      vox_ready <= (count_nxt != FULL_CNT);
    end
  end

  // Pending request tracking
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      disp_q   <= '0;
      rd_theta <= '0;
      rd_pend  <= 1'b0;
      rd_new   <= 1'b0;
      fl_pend  <= 1'b0;
    end else begin
      if (theta_chg) begin
        disp_q   <= disp_theta;
        rd_theta <= disp_theta;
        rd_pend  <= 1'b1;
        // The in-flight angle is latched in buf_theta_read, so a change now is a fresh request.
        rd_new   <= (in_rd && !rd_done) || grant_rd;
      end else if (rd_done) begin
        rd_pend  <= rd_new;
        rd_new   <= 1'b0;
      end
      // A repeated request while one is pending simply merges.
      if (fl_exit)        fl_pend <= 1'b0;
      else if (flush_req) fl_pend <= 1'b1;
    end
  end

  // Control FSM with registered buffer strobes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      wait_skip       <= 1'b0;
      col_valid       <= 1'b0;
      col_theta       <= '0;
      flush_done      <= 1'b0;
      buf_flush       <= 1'b0;
      buf_new_data    <= 1'b0;
      buf_radius      <= '0;
      buf_theta_write <= '0;
      buf_z           <= '0;
      buf_theta_read  <= '0;
    end else begin
      col_valid    <= 1'b0;
      flush_done   <= 1'b0;
      buf_flush    <= 1'b0;
      buf_new_data <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state          <= RD_ISSUE;
            buf_theta_read <= rd_theta;
          end else if (grant_fl) begin
            state     <= FL_ISSUE;
            buf_flush <= 1'b1;
          end else if (grant_wr) begin
            state        <= WR_ISSUE;
            buf_new_data <= 1'b1;
            {buf_radius, buf_theta_write, buf_z} <= mem[rd_ptr];
          end
        end
        RD_ISSUE: begin
          state     <= RD_WAIT;
          wait_skip <= 1'b1;
        end
        RD_WAIT: begin
          if (wait_skip) begin
            wait_skip <= 1'b0;
            col_valid <= 1'b1;
            col_theta <= buf_theta_read;
          end else begin
            state <= IDLE;
          end
        end
        WR_ISSUE, FL_ISSUE: begin
          // Buffer raises busy one cycle after a strobe, hence the skip cycle.
          state     <= (state == WR_ISSUE) ? WR_WAIT : FL_WAIT;
          wait_skip <= 1'b1;
        end
        WR_WAIT: begin
          if (wait_skip)      wait_skip <= 1'b0;
          else if (!buf_busy) state     <= IDLE;
        end
        FL_WAIT: begin
          if (wait_skip) begin
            wait_skip <= 1'b0;
          end else if (!buf_busy) begin
            state      <= IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROT_SCHED_STATS_EN
  // Miss: the pending angle was replaced before its read was granted.
  logic miss;
  assign miss = theta_chg && ((rd_pend && !in_rd && !grant_rd) || rd_new);

  always_ff @(posedge clk_in) begin
    if (rst_in)                                    read_miss_count <= 16'd0;
    else if (miss && (read_miss_count != 16'hFFFF)) read_miss_count <= read_miss_count + 16'd1;
  end
`else
  assign read_miss_count = 16'd0;
`endif

endmodule
